// File: rtl/mu0_sequencer.sv
// mu0_sequencer: fetch/execute phase sequencer for the MU0 processor.
// Holds the instruction register, presents the opcode to the decoder,
// stalls on ramReady=0 and counts retired instructions (wraps at 2^16).
// Optional feature macro: MU0_HALT_RESUME_EN adds the resume input, which
// lets HALT return to FETCH without a reset.
//
// state | meaning
// FETCH | read instruction word from RAM, load IR
// EXEC1 | first execute cycle (STA finishes here)
// EXEC2 | second execute cycle (LDA/ADD/SUB)
// HALT  | stopped after STP; inputs ignored
module mu0_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ramData,
  input  logic        ramReady,
  input  logic        extra,
`ifdef MU0_HALT_RESUME_EN
  input  logic        resume,
`endif
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic [3:0]  mux2r,
  output logic [11:0] irAddr,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_STP = 4'd7;

  state_t      state, state_next;
  logic [15:0] ir;
  logic        load_ir;
  logic        inc_retired;

  // State, instruction register and retired counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      ir      <= 16'h0000;
      retired <= 16'h0000;
    end else begin
      state <= state_next;
      if (load_ir)     ir      <= ramData;
      if (inc_retired) retired <= retired + 16'd1;
    end
  end

  // Next-state decode; a low ramReady leaves every non-HALT state frozen.
  always_comb begin
    state_next  = state;
    load_ir     = 1'b0;
    inc_retired = 1'b0;
    case (state)
      S_FETCH: begin
        if (ramReady) begin
          load_ir = 1'b1;
          if (ramData[15:12] == OP_STP) begin
            state_next  = S_HALT;
            inc_retired = 1'b1;
          end else if (extra || (ramData[15:12] == OP_STA)) begin
            state_next = S_EXEC1;
          end else begin
            state_next  = S_FETCH;
            inc_retired = 1'b1;
          end
        end
      end
      S_EXEC1: begin
        if (ramReady) begin
          if (ir[15:12] == OP_STA) begin
            state_next  = S_FETCH;
            inc_retired = 1'b1;
          end else begin
            state_next = S_EXEC2;
          end
        end
      end
      S_EXEC2: begin
        if (ramReady) begin
          state_next  = S_FETCH;
          inc_retired = 1'b1;
        end
      end
      S_HALT: begin
`ifdef MU0_HALT_RESUME_EN
        if (resume) state_next = S_FETCH;
`else
        state_next = S_HALT;
`endif
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Phase flags and decoder opcode; in FETCH the decoder sees the word still on the bus.
  always_comb begin
    fetch  = (state == S_FETCH);
    exec1  = (state == S_EXEC1);
    exec2  = (state == S_EXEC2);
    halted = (state == S_HALT);
    mux2r  = (state == S_FETCH) ? ramData[15:12] : ir[15:12];
    irAddr = ir[11:0];
  end

endmodule
